// File: rtl/gol_run_controller.sv
// gol_run_controller
//   Sequencer for an 8x8 Game of Life board. Holds the board register, presents
//   it to an external combinational next-generation datapath, and captures the
//   datapath result once per generation tick. Handles load/start/stop/step
//   commands, counts generations and halts automatically on extinction, still
//   life, period-2 oscillation or a generation limit.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   load         copy seed_in into the board (level, highest priority)
//   seed_in      seed pattern, bit index r*8+c
//   start        enter free-running evolution
//   stop         pause evolution, return to IDLE
//   step         advance one generation from IDLE or HALT
//   period_in    clocks per generation (0 behaves as 1), sampled live
//   gen_limit    halt after this many generations since load (0 = no limit)
//   next_board   datapath result computed from board_out
//   board_out    current board
//   gen_count    generations since last load, saturating
//   running      high while in RUN
//   gen_tick     high during the cycle whose closing edge advances the board
//   done         one-cycle pulse after the edge that enters HALT
//   halt_reason  0 none, 1 extinct, 2 still, 3 period-2, 4 limit
module gol_run_controller #(
  parameter int BOARD_W = 64,
  parameter int DIV_W   = 24,
  parameter int GEN_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BOARD_W-1:0] seed_in,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [DIV_W-1:0]   period_in,
  input  logic [GEN_W-1:0]   gen_limit,
  input  logic [BOARD_W-1:0] next_board,
  output logic [BOARD_W-1:0] board_out,
  output logic [GEN_W-1:0]   gen_count,
  output logic               running,
  output logic               gen_tick,
  output logic               done,
  output logic [2:0]         halt_reason
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state;
  logic [BOARD_W-1:0] prev_board;
  logic               prev_valid;
  logic [DIV_W-1:0]   tick;
  logic [DIV_W-1:0]   period_m1;
  logic               advance;
  logic [2:0]         halt_code;

  // First matching condition wins; evaluated on the board about to be committed.
  function automatic logic [2:0] halt_check(
    input logic [BOARD_W-1:0] nb,
    input logic [BOARD_W-1:0] cur,
    input logic [BOARD_W-1:0] prev,
    input logic               pv,
    input logic [GEN_W-1:0]   cnt,
    input logic [GEN_W-1:0]   lim
  );
    logic [GEN_W-1:0] cnt_inc;
    cnt_inc = cnt + GEN_W'(1);
    if (nb == '0)                          return 3'd1;
    else if (nb == cur)                    return 3'd2;
    else if (pv && (nb == prev))           return 3'd3;
    else if ((lim != '0) && (cnt_inc == lim)) return 3'd4;
    else                                   return 3'd0;
  endfunction

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
    return (v == '1) ? v : v + GEN_W'(1);
  endfunction

  // A zero period behaves as one clock per generation.
  always_comb begin
    period_m1 = '0;
    if (period_in != '0) period_m1 = period_in - DIV_W'(1);
  end

  // Advance decision follows load > stop > start > step. Using >= lets a live
  // shrink of period_in advance on the next cycle instead of wrapping tick.
  always_comb begin
    advance = 1'b0;
    if (reset && !load && !stop) begin
      if (state == S_RUN) advance = (tick >= period_m1);
      else                advance = !start && step;
    end
  end

  assign gen_tick  = advance;
  assign halt_code = halt_check(next_board, board_out, prev_board, prev_valid,
                                gen_count, gen_limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      board_out   <= '0;
      prev_board  <= '0;
      prev_valid  <= 1'b0;
      gen_count   <= '0;
      tick        <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      halt_reason <= 3'd0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state       <= S_IDLE;
        board_out   <= seed_in;
        gen_count   <= '0;
        prev_valid  <= 1'b0;
        halt_reason <= 3'd0;
        tick        <= '0;
        running     <= 1'b0;
      end else if (stop) begin
        state   <= S_IDLE;
        tick    <= '0;
        running <= 1'b0;
      end else if (advance) begin
        prev_board <= board_out;
        board_out  <= next_board;
        gen_count  <= sat_inc(gen_count);
        prev_valid <= 1'b1;
        tick       <= '0;
        if (halt_code != 3'd0) begin
          state       <= S_HALT;
          halt_reason <= halt_code;
          done        <= 1'b1;
          running     <= 1'b0;
        end
      end else if (start && (state != S_RUN)) begin
        state       <= S_RUN;
        tick        <= '0;
        halt_reason <= 3'd0;
        running     <= 1'b1;
      end else if (state == S_RUN) begin
        tick <= tick + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gol_run_controller.sv
// Directed testbench for gol_run_controller. A Game of Life next-generation
// model (dead cells beyond the 8x8 edge) stands in for the external datapath.
module tb_gol_run_controller;

  localparam int BOARD_W = 64;
  localparam int DIV_W   = 24;
  localparam int GEN_W   = 16;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0E08_0400;

  logic               clk;
  logic               reset;
  logic               load;
  logic [BOARD_W-1:0] seed_in;
  logic               start;
  logic               stop;
  logic               step;
  logic [DIV_W-1:0]   period_in;
  logic [GEN_W-1:0]   gen_limit;
  logic [BOARD_W-1:0] next_board;
  logic [BOARD_W-1:0] board_out;
  logic [GEN_W-1:0]   gen_count;
  logic               running;
  logic               gen_tick;
  logic               done;
  logic [2:0]         halt_reason;

  int checks;
  int errors;

  gol_run_controller #(
    .BOARD_W(BOARD_W), .DIV_W(DIV_W), .GEN_W(GEN_W)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .seed_in(seed_in),
    .start(start), .stop(stop), .step(step), .period_in(period_in),
    .gen_limit(gen_limit), .next_board(next_board), .board_out(board_out),
    .gen_count(gen_count), .running(running), .gen_tick(gen_tick),
    .done(done), .halt_reason(halt_reason)
  );

  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              if (b[rr*8+cc]) cnt++;
          end
        end
        n[r*8+c] = b[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  assign next_board = life_next(board_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b1; start = 1'b1; stop = 1'b1; step = 1'b1;
    seed_in = '1; period_in = '1; gen_limit = '1;
    repeat (3) cyc();
    checks++; if (board_out !== 64'h0) begin errors++; $display("FAIL rst_board got %h exp 0", board_out); end
    checks++; if (gen_count !== 16'h0) begin errors++; $display("FAIL rst_gen got %0d exp 0", gen_count); end
    checks++; if ({running, done, gen_tick, halt_reason} !== 6'b0) begin errors++;
      $display("FAIL rst_ctrl got run=%b done=%b tick=%b reason=%0d exp all 0", running, done, gen_tick, halt_reason); end
    load = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    seed_in = '0; period_in = '0; gen_limit = '0;
    reset = 1'b1;
    repeat (3) cyc();
    checks++; if (board_out !== 64'h0 || gen_count !== 16'h0) begin errors++;
      $display("FAIL post_rst_data got board=%h gen=%0d exp 0/0", board_out, gen_count); end
    checks++; if ({running, done, gen_tick, halt_reason} !== 6'b0) begin errors++;
      $display("FAIL post_rst_ctrl got run=%b done=%b tick=%b reason=%0d exp all 0", running, done, gen_tick, halt_reason); end
  endtask

  task automatic test_blinker();
    load = 1'b1; seed_in = BLINK_H; cyc(); load = 1'b0;
    checks++; if (board_out !== BLINK_H || gen_count !== 16'd0) begin errors++;
      $display("FAIL blink_load got board=%h gen=%0d exp %h/0", board_out, gen_count, BLINK_H); end
    period_in = 24'd4; start = 1'b1; cyc(); start = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL blink_running got %b exp 1", running); end
    repeat (2) cyc();
    checks++; if (board_out !== BLINK_H || gen_tick !== 1'b0) begin errors++;
      $display("FAIL blink_hold got board=%h tick=%b exp %h/0", board_out, gen_tick, BLINK_H); end
    cyc();
    checks++; if (gen_tick !== 1'b1) begin errors++; $display("FAIL blink_tick got %b exp 1", gen_tick); end
    cyc();
    checks++; if (board_out !== BLINK_V || gen_count !== 16'd1 || running !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL blink_gen1 got board=%h gen=%0d run=%b done=%b exp %h/1/1/0", board_out, gen_count, running, done, BLINK_V); end
    repeat (4) cyc();
    checks++; if (board_out !== BLINK_H || gen_count !== 16'd2) begin errors++;
      $display("FAIL blink_gen2 got board=%h gen=%0d exp %h/2", board_out, gen_count, BLINK_H); end
    checks++; if (done !== 1'b1 || halt_reason !== 3'd3 || running !== 1'b0) begin errors++;
      $display("FAIL blink_halt got done=%b reason=%0d run=%b exp 1/3/0", done, halt_reason, running); end
    cyc();
    checks++; if (done !== 1'b0 || board_out !== BLINK_H || halt_reason !== 3'd3) begin errors++;
      $display("FAIL blink_after got done=%b board=%h reason=%0d exp 0/%h/3", done, board_out, halt_reason, BLINK_H); end
  endtask

  task automatic test_still();
    load = 1'b1; seed_in = BLOCK; cyc(); load = 1'b0;
    period_in = 24'd1; start = 1'b1; cyc(); start = 1'b0;
    cyc();
    checks++; if (board_out !== BLOCK || gen_count !== 16'd1 || halt_reason !== 3'd2 || done !== 1'b1) begin errors++;
      $display("FAIL still got board=%h gen=%0d reason=%0d done=%b exp %h/1/2/1", board_out, gen_count, halt_reason, done, BLOCK); end
  endtask

  task automatic test_step_extinct();
    load = 1'b1; seed_in = SINGLE; cyc(); load = 1'b0;
    step = 1'b1; cyc(); step = 1'b0;
    checks++; if (board_out !== 64'h0 || halt_reason !== 3'd1 || done !== 1'b1 || gen_count !== 16'd1 || running !== 1'b0) begin errors++;
      $display("FAIL extinct got board=%h reason=%0d done=%b gen=%0d run=%b exp 0/1/1/1/0", board_out, halt_reason, done, gen_count, running); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL extinct_done_pulse got %b exp 0", done); end
    step = 1'b1; cyc(); step = 1'b0;
    checks++; if (gen_count !== 16'd2 || halt_reason !== 3'd1 || done !== 1'b1) begin errors++;
      $display("FAIL rehalt got gen=%0d reason=%0d done=%b exp 2/1/1", gen_count, halt_reason, done); end
  endtask

  task automatic test_limit();
    int ticks;
    load = 1'b1; seed_in = GLIDER; gen_limit = 16'd5; period_in = 24'd2; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    ticks = 0;
    repeat (20) begin
      if (gen_tick) ticks++;
      cyc();
    end
    checks++; if (ticks != 5) begin errors++; $display("FAIL limit_ticks got %0d exp 5", ticks); end
    checks++; if (halt_reason !== 3'd4 || gen_count !== 16'd5 || running !== 1'b0) begin errors++;
      $display("FAIL limit_halt got reason=%0d gen=%0d run=%b exp 4/5/0", halt_reason, gen_count, running); end
    gen_limit = '0;
  endtask

  task automatic test_priority_stop();
    load = 1'b1; start = 1'b1; seed_in = BLINK_H; period_in = 24'd8; cyc();
    load = 1'b0; start = 1'b0;
    checks++; if (running !== 1'b0 || board_out !== BLINK_H || gen_count !== 16'd0) begin errors++;
      $display("FAIL load_prio got run=%b board=%h gen=%0d exp 0/%h/0", running, board_out, gen_count, BLINK_H); end
    start = 1'b1; cyc(); start = 1'b0;
    repeat (2) cyc();
    stop = 1'b1;
    checks++; if (gen_tick !== 1'b0) begin errors++; $display("FAIL stop_tick got %b exp 0", gen_tick); end
    cyc(); stop = 1'b0;
    checks++; if (running !== 1'b0 || board_out !== BLINK_H || gen_count !== 16'd0) begin errors++;
      $display("FAIL stop got run=%b board=%h gen=%0d exp 0/%h/0", running, board_out, gen_count, BLINK_H); end
    start = 1'b1; cyc(); start = 1'b0;
    repeat (6) cyc();
    checks++; if (gen_tick !== 1'b0 || board_out !== BLINK_H) begin errors++;
      $display("FAIL restart_early got tick=%b board=%h exp 0/%h", gen_tick, board_out, BLINK_H); end
    cyc();
    checks++; if (gen_tick !== 1'b1) begin errors++; $display("FAIL restart_tick got %b exp 1", gen_tick); end
    cyc();
    checks++; if (board_out !== BLINK_V || gen_count !== 16'd1) begin errors++;
      $display("FAIL restart_adv got board=%h gen=%0d exp %h/1", board_out, gen_count, BLINK_V); end
  endtask

  task automatic test_reset_mid_run();
    cyc();
    #2 reset = 1'b0;
    #1;
    checks++; if (board_out !== 64'h0 || running !== 1'b0 || gen_count !== 16'd0) begin errors++;
      $display("FAIL mid_rst got board=%h run=%b gen=%0d exp 0/0/0", board_out, running, gen_count); end
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_blinker();
    test_still();
    test_step_extinct();
    test_limit();
    test_priority_stop();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gol_run_controller.md
Name: gol_run_controller

Overview:
- Sequencer for the 8x8 Game of Life next-generation datapath. It owns the board register and drives the current board into the external combinational datapath.
- Each generation tick, it captures the datapath result. Tick rate is programmable.
- It supports load, start, stop and single-step commands, counts generations, and auto-halts on extinction, still life, period-2 oscillation or a generation limit.

Parameters:
- BOARD_W, 64, board bits; bit index r*8+c.
- DIV_W, 24, width of tick-period field.
- GEN_W, 16, width of generation counter/limit.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  copy seed_in into board (level, sampled each cycle).
- seed_in  input  BOARD_W  seed pattern.
- start  input  1  begin free-running evolution.
- stop  input  1  pause evolution, return to IDLE.
- step  input  1  advance exactly one generation from IDLE.
- period_in  input  DIV_W  clocks per generation; 0 treated as 1.
- gen_limit  input  GEN_W  halt after this many generations since load; 0 = no limit.
- next_board  input  BOARD_W  datapath result for board_out.
- board_out  output  BOARD_W  current board (feeds datapath and display).
- gen_count  output  GEN_W  generations since last load.
- running  output  1  high in RUN.
- gen_tick  output  1  1-cycle pulse on the cycle the board advances.
- done  output  1  1-cycle pulse on entry to HALT.
- halt_reason  output  3  0 none, 1 extinct, 2 still, 3 period-2, 4 limit.

Behaviour:
- Reset (reset=0, async) sets:
  - state IDLE;
  - board_out, prev_board, gen_count, tick counter = 0;
  - prev_valid = 0;
  - running, gen_tick, done = 0;
  - halt_reason = 0.
- Command priority when several are asserted in one cycle: load > stop > start > step.
- load (any state):
  - next edge: board_out = seed_in, gen_count = 0, prev_valid = 0, halt_reason = 0, tick = 0;
  - state becomes IDLE.
- States:
  - IDLE: hold board. start -> RUN with tick = 0. step -> advance once at the next edge and stay IDLE, unless a halt condition fires, then go to HALT.
  - RUN:
    - tick increments each cycle;
    - when tick == max(period_in,1)-1, advance and reset tick to 0;
    - the first advance lands on the P-th edge after the edge that entered RUN;
    - stop -> IDLE with tick cleared and no advance that cycle;
    - period_in is sampled live; if tick already >= P-1, advance on the next cycle.
  - HALT: hold board and halt_reason. start -> RUN (halt_reason cleared, gen_count continues). step -> single advance as in IDLE. stop -> IDLE.
- Advance edge updates:
  - prev_board = board_out, board_out = next_board;
  - gen_count += 1, saturating at all-ones;
  - prev_valid = 1;
  - gen_tick is high in the cycle containing that edge.
- Halt checks are evaluated on next_board in the advance cycle; the first match in this order wins:
  - next_board == 0 -> extinct (1);
  - next_board == board_out -> still (2);
  - prev_valid && next_board == prev_board -> period-2 (3);
  - gen_limit != 0 && gen_count+1 == gen_limit -> limit (4).
- On a match:
  - the advance still commits;
  - state -> HALT, halt_reason set, done pulses for one cycle (the cycle after the advance edge).
- An extinct or still board reached in HALT re-triggers HALT on the next advance; this is expected.
- running = (state == RUN), registered.
- Reset mid-RUN aborts immediately: board is lost, all outputs return to reset values.

Test Plan:
- Reset with every input active -> board_out=0, gen_count=0, running=0, done=0, halt_reason=0; then release reset with all inputs 0 -> outputs hold those values.
- load seed 0x0000_0000_1C00_0000 (horizontal blinker), period_in=4, start:
  - board alternates 0x0000_0008_0808_0000 / 0x0000_0000_1C00_0000 every 4 clocks;
  - after gen 2, done pulses, halt_reason=3, gen_count=2, running=0.
- load 2x2 block 0x0000_0018_1800_0000, start, period 1 -> after gen 1, halt_reason=2, board unchanged, gen_count=1.
- load single cell 0x0000_0000_0800_0000, step -> board=0, halt_reason=1, done pulse, state HALT; a further step re-halts with reason 1 and gen_count=2.
- Glider seed, gen_limit=5, period 2, start -> exactly 5 gen_tick pulses, halt_reason=4, gen_count=5.
- Priority and stop:
  - load+start in the same cycle -> load wins, IDLE;
  - stop asserted mid-RUN at tick=2 of period 8 -> no advance, IDLE;
  - a later start -> first advance 8 clocks later.
